// File: rtl/alu_wb_buffer.sv
// alu_wb_buffer: write-back buffer sitting between the ALU result interface
// and the register-file write port. A 2-entry FIFO absorbs results while the
// register file is stalled. On the way out, each entry may write the register
// file and may update the architectural NZCV flag register.
// Optional macro WB_FWD_BYPASS_EN adds fwd_valid/fwd_rd/fwd_data. These
// outputs expose the head entry so that operand fetch can forward a pending
// result.
module alu_wb_buffer #(
  parameter int N     = 32,
  parameter int AW    = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_result,
  input  logic [3:0]       in_flags,
  input  logic [AW-1:0]    in_rd,
  input  logic             in_wr_en,
  input  logic             in_set_flags,
  input  logic             rf_busy,
  output logic             rf_we,
  output logic [AW-1:0]    rf_waddr,
  output logic [N-1:0]     rf_wdata,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] wb_count
`ifdef WB_FWD_BYPASS_EN
  ,
  output logic             fwd_valid,
  output logic [AW-1:0]    fwd_rd,
  output logic [N-1:0]     fwd_data
`endif
);

  typedef struct packed {
    logic [N-1:0]  result;
    logic [3:0]    flags;
    logic [AW-1:0] rd;
    logic          wr_en;
    logic          set_flags;
  } entry_t;

  entry_t fifo_mem_reg [2];

  logic [1:0]       count_reg;
  logic [1:0]       count_next;
  logic             wptr_reg;
  logic             rptr_reg;
  logic             rf_we_reg;
  logic [AW-1:0]    rf_waddr_reg;
  logic [N-1:0]     rf_wdata_reg;
  logic [3:0]       flags_reg;
  logic [CNT_W-1:0] wb_count_reg;

  logic   push;
  logic   pop;
  entry_t head;

  // in_ready depends only on the registered count and on reset. It has no
  // path from in_valid or rf_busy, so a full buffer refuses a push even on a
  // cycle where it also pops.
  assign in_ready = (count_reg < 2'd2) && !rst;
  assign push     = in_valid && in_ready;
  assign pop      = (count_reg != 2'd0) && !rf_busy;
  assign head     = fifo_mem_reg[rptr_reg];

  // Occupancy update; a push and a pop in the same cycle leave the count unchanged
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // Entry storage: this holds data only and has no reset, because the count
  // decides which entries are valid
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_reg[wptr_reg] <= '{result:    in_result,
                                  flags:     in_flags,
                                  rd:        in_rd,
                                  wr_en:     in_wr_en,
                                  set_flags: in_set_flags};
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= 2'd0;
      wptr_reg  <= 1'b0;
      rptr_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (push) wptr_reg <= ~wptr_reg;
      if (pop)  rptr_reg <= ~rptr_reg;
    end
  end

  // Drain side. Each popped entry can drive a single-cycle write strobe and
  // can update the flag register. The address and data outputs keep their
  // previous values when the popped entry does not write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
      flags_reg    <= 4'b0000;
      wb_count_reg <= '0;
    end else begin
      rf_we_reg <= pop && head.wr_en;
      if (pop && head.wr_en) begin
        rf_waddr_reg <= head.rd;
        rf_wdata_reg <= head.result;
        wb_count_reg <= wb_count_reg + CNT_W'(1);
      end
      if (pop && head.set_flags) begin
        flags_reg <= head.flags;
      end
    end
  end

  assign rf_we    = rf_we_reg;
  assign rf_waddr = rf_waddr_reg;
  assign rf_wdata = rf_wdata_reg;
  assign flags    = flags_reg;
  assign wb_count = wb_count_reg;

`ifdef WB_FWD_BYPASS_EN
  // Forwarding view of the oldest pending result, taken from registered state only
  assign fwd_valid = (count_reg != 2'd0) && head.wr_en;
  assign fwd_rd    = head.rd;
  assign fwd_data  = head.result;
`endif

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Directed testbench for alu_wb_buffer. It exercises the forwarding outputs
// as well when WB_FWD_BYPASS_EN is defined.
module tb_alu_wb_buffer;

  localparam int N     = 32;
  localparam int AW    = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_result;
  logic [3:0]       in_flags;
  logic [AW-1:0]    in_rd;
  logic             in_wr_en;
  logic             in_set_flags;
  logic             rf_busy;
  logic             rf_we;
  logic [AW-1:0]    rf_waddr;
  logic [N-1:0]     rf_wdata;
  logic [3:0]       flags;
  logic [CNT_W-1:0] wb_count;
`ifdef WB_FWD_BYPASS_EN
  logic             fwd_valid;
  logic [AW-1:0]    fwd_rd;
  logic [N-1:0]     fwd_data;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_wb_buffer #(.N(N), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_flags     (in_flags),
    .in_rd        (in_rd),
    .in_wr_en     (in_wr_en),
    .in_set_flags (in_set_flags),
    .rf_busy      (rf_busy),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .flags        (flags),
    .wb_count     (wb_count)
`ifdef WB_FWD_BYPASS_EN
    ,
    .fwd_valid    (fwd_valid),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [N-1:0] res, input logic [3:0] fl,
                       input logic [AW-1:0] rd, input logic we, input logic sf);
    in_valid     = v;
    in_result    = res;
    in_flags     = fl;
    in_rd        = rd;
    in_wr_en     = we;
    in_set_flags = sf;
  endtask

  initial begin
    rst     = 1'b1;
    rf_busy = 1'b0;
    drive(1'b0, '0, 4'b0000, '0, 1'b0, 1'b0);

    // ---- reset state
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_flags", flags, 0);
    chk("rst_wb_count", wb_count, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1);
    $display("step reset: in_ready=%0d rf_we=%0d", in_ready, rf_we);

    // ---- single op, 2 edges of latency to the write strobe
    drive(1'b1, 32'h0000_00A5, 4'b0100, 4'd3, 1'b1, 1'b1);
    tick();                              // accept
    drive(1'b0, '0, 4'b0000, '0, 1'b0, 1'b0);
    chk("t1_we_early", rf_we, 0);
    tick();                              // pop
    chk("t1_we", rf_we, 1);
    chk("t1_waddr", rf_waddr, 3);
    chk("t1_wdata", rf_wdata, 32'hA5);
    chk("t1_flags", flags, 4'b0100);
    chk("t1_wb_count", wb_count, 1);
    tick();
    chk("t1_we_one_cycle", rf_we, 0);
    $display("step single op: waddr=%0d wdata=%0h flags=%b", rf_waddr, rf_wdata, flags);

    // ---- 4 back-to-back ops
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i * 32'h11), 4'b1111, AW'(i), 1'b1, 1'b0);
      chk("b2b_in_ready", in_ready, 1);
      tick();
      if (i >= 2) begin
        chk("b2b_we", rf_we, 1);
        chk("b2b_waddr", rf_waddr, 64'(i - 1));
        chk("b2b_wdata", rf_wdata, 64'((i - 1) * 32'h11));
      end
      $display("step b2b op %0d accepted", i);
    end
    drive(1'b0, '0, 4'b0000, '0, 1'b0, 1'b0);
    tick();
    chk("b2b_we4", rf_we, 1);
    chk("b2b_waddr4", rf_waddr, 4);
    chk("b2b_wdata4", rf_wdata, 32'h44);
    tick();
    chk("b2b_we_end", rf_we, 0);
    chk("b2b_wb_count", wb_count, 5);
    chk("b2b_flags_kept", flags, 4'b0100);

    // ---- stall with 3 offered ops
    rf_busy = 1'b1;
    drive(1'b1, 32'h80, 4'b0000, 4'd8, 1'b1, 1'b0);
    chk("st_ready_a", in_ready, 1);
    tick();                              // e1: accept A
    drive(1'b1, 32'h90, 4'b0000, 4'd9, 1'b1, 1'b0);
    chk("st_ready_b", in_ready, 1);
    tick();                              // e2: accept B
    drive(1'b1, 32'hA0, 4'b0000, 4'd10, 1'b1, 1'b0);
    chk("st_ready_full", in_ready, 0);
    tick();                              // e3
    chk("st_ready_full2", in_ready, 0);
    chk("st_no_we", rf_we, 0);
    tick();                              // e4
    tick();                              // e5
    chk("st_ready_full3", in_ready, 0);
    chk("st_no_we2", rf_we, 0);
    rf_busy = 1'b0;
    tick();                              // e6: pop A
    chk("st_we_a", rf_we, 1);
    chk("st_waddr_a", rf_waddr, 8);
    chk("st_wdata_a", rf_wdata, 32'h80);
    chk("st_ready_after_pop", in_ready, 1);
    tick();                              // e7: pop B, accept C
    drive(1'b0, '0, 4'b0000, '0, 1'b0, 1'b0);
    chk("st_waddr_b", rf_waddr, 9);
    chk("st_wdata_b", rf_wdata, 32'h90);
    tick();                              // e8: pop C
    chk("st_we_c", rf_we, 1);
    chk("st_waddr_c", rf_waddr, 10);
    chk("st_wdata_c", rf_wdata, 32'hA0);
    tick();
    chk("st_we_end", rf_we, 0);
    chk("st_wb_count", wb_count, 8);
    $display("step stall: wb_count=%0d", wb_count);

    // ---- flags-only op, then write-only op
    drive(1'b1, 32'h55, 4'b1001, 4'd2, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h77, 4'b0110, 4'd7, 1'b1, 1'b0);
    tick();                              // pop flags-only op, accept second
    drive(1'b0, '0, 4'b0000, '0, 1'b0, 1'b0);
    chk("fo_no_we", rf_we, 0);
    chk("fo_flags", flags, 4'b1001);
    chk("fo_waddr_hold", rf_waddr, 10);
    chk("fo_wdata_hold", rf_wdata, 32'hA0);
    tick();
    chk("wo_we", rf_we, 1);
    chk("wo_waddr", rf_waddr, 7);
    chk("wo_wdata", rf_wdata, 32'h77);
    chk("wo_flags_kept", flags, 4'b1001);
    chk("wo_wb_count", wb_count, 9);
    tick();
    $display("step flags/write split: flags=%b waddr=%0d", flags, rf_waddr);

    // ---- reset with 2 buffered entries
    rf_busy = 1'b1;
    drive(1'b1, 32'hC0, 4'b1111, 4'd12, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'hD0, 4'b1111, 4'd13, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, 4'b0000, '0, 1'b0, 1'b0);
    chk("rr_full", in_ready, 0);
    rst = 1'b1;
    tick();
    chk("rr_ready_in_rst", in_ready, 0);
    chk("rr_flags", flags, 0);
    chk("rr_wb_count", wb_count, 0);
    chk("rr_waddr", rf_waddr, 0);
    rst     = 1'b0;
    rf_busy = 1'b0;
    #1;
    chk("rr_ready_empty", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rr_no_we", rf_we, 0);
    end
    chk("rr_wb_count_end", wb_count, 0);
    chk("rr_flags_end", flags, 0);
    $display("step reset mid-op: wb_count=%0d flags=%b", wb_count, flags);

`ifdef WB_FWD_BYPASS_EN
    // ---- forwarding view of a stalled entry
    chk("fwd_empty", fwd_valid, 0);
    rf_busy = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 4'b0000, 4'd5, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 4'b0000, '0, 1'b0, 1'b0);
    chk("fwd_valid", fwd_valid, 1);
    chk("fwd_rd", fwd_rd, 5);
    chk("fwd_data", fwd_data, 32'hDEAD_BEEF);
    tick();
    chk("fwd_valid_held", fwd_valid, 1);
    rf_busy = 1'b0;
    tick();
    chk("fwd_valid_gone", fwd_valid, 0);
    chk("fwd_we", rf_we, 1);
    chk("fwd_waddr", rf_waddr, 5);
    $display("step forwarding: fwd_valid=%0d", fwd_valid);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_wb_buffer.md
Name: alu_wb_buffer

Overview:
- Consumer end of the ALU result interface: accepts ALU result, flags and destination register per operation over a valid/ready handshake.
- Buffers results in a 2-entry FIFO and drains them into the register-file write port; also holds the architectural NZCV flag register.
- Sits between the ALU output (including move results) and the register file. Lets the ALU issue back-to-back while the register file port is stalled.

Parameters:
- N, 32, data width of ALU result and register-file write data
- AW, 4, register address width (2**AW registers)
- CNT_W, 16, width of the write-back statistics counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ALU presents an operation result
- in_ready  out  1  buffer can accept; transfer when in_valid && in_ready at a clock edge
- in_result  in  N  ALU result
- in_flags  in  4  {N,Z,C,V} from the ALU
- in_rd  in  AW  destination register
- in_wr_en  in  1  result is to be written to in_rd
- in_set_flags  in  1  in_flags is to update the flag register
- rf_busy  in  1  register-file port stalled; no drain while high
- rf_we  out  1  register-file write strobe, one cycle per drained entry with wr_en
- rf_waddr  out  AW  write address
- rf_wdata  out  N  write data
- flags  out  4  architectural NZCV register
- wb_count  out  CNT_W  number of rf_we pulses since reset

Behaviour:
- Reset (rst high at an edge):
  - FIFO count=0, pointers=0.
  - rf_we=0, rf_waddr=0, rf_wdata=0, flags=4'b0000, wb_count=0.
  - in_ready=0 while rst is high; in_ready=1 in the first cycle after rst falls.
  - Reset mid-operation discards all buffered entries; no write is issued.
- in_ready:
  - Equals (count<2) and !rst.
  - Depends only on registered state, with no combinational path from in_valid or rf_busy.
  - At count=2 no push, even if a pop occurs the same cycle.
- Push: on a transfer, {result, flags, rd, wr_en, set_flags} is written at the write pointer. The pointer wraps 1->0.
- Pop: at an edge where count>0 and rf_busy=0, the head entry is removed and the read pointer wraps 1->0. On that same edge:
  - If head.wr_en: rf_we<=1, rf_waddr<=head.rd, rf_wdata<=head.result, wb_count<=wb_count+1 (wraps at 2**CNT_W).
  - Otherwise: rf_we<=0, and rf_waddr/rf_wdata hold their previous values.
  - If head.set_flags: flags<=head.flags.
  - Entries with wr_en=0 and set_flags=0 still pop, taking 1 cycle.
- At any edge without a pop, rf_we<=0. rf_we is never high for more than one cycle per entry.
- Simultaneous push and pop (count=1): count stays 1 and FIFO order is preserved.
- Latency: on an empty buffer with rf_busy=0, an operation accepted at edge k pops at edge k+1. rf_we is high in the cycle after edge k+1, and flags update at edge k+1.
- Throughput: 1 op/cycle sustained while rf_busy=0.
- rf_busy asserted: the head is held, the FIFO fills to 2, and in_ready then drops. Draining resumes at the first edge with rf_busy=0.

Optional Feature:
- Macro WB_FWD_BYPASS_EN.
- When defined, three extra outputs are compiled in:
  - fwd_valid (1) = count>0 && head.wr_en
  - fwd_rd (AW) = head.rd
  - fwd_data (N) = head.result
  - All three are combinational from registered FIFO state, so operand fetch can forward a pending result. When count=0, fwd_valid=0 and fwd_rd/fwd_data are don't-care.
- When undefined: these ports and their logic do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset, then one op: result=0x0000_00A5, rd=3, wr_en=1, set_flags=1, flags=4'b0100 -> rf_we high exactly 1 cycle, 2 edges after acceptance, with rf_waddr=3, rf_wdata=0xA5; flags=4'b0100; wb_count=1.
- Back-to-back 4 ops, rd=1..4, data 0x11..0x44, rf_busy=0 -> in_ready stays 1; four consecutive rf_we pulses in order 1..4 / 0x11..0x44; wb_count=4.
- rf_busy=1 for 5 cycles while 3 ops are offered -> first 2 accepted, in_ready=0, third stalls with in_valid held. After rf_busy=0, writes occur in order and the third op is accepted the cycle after the first pop.
- Ops with wr_en=0, set_flags=1, flags=4'b1001 followed by wr_en=1, set_flags=0, rd=7 -> no rf_we for the first op; flags=4'b1001; rd=7 written; flags unchanged.
- Reset asserted with 2 entries buffered and rf_busy=1 -> after reset count=0, no rf_we ever pulses for the discarded entries, flags=0, wb_count=0.
- With WB_FWD_BYPASS_EN defined and rf_busy=1, push rd=5, data 0xDEAD_BEEF -> fwd_valid=1, fwd_rd=5, fwd_data=0xDEAD_BEEF until the entry pops; then fwd_valid=0.
